spi_master_slave: RTL and testbench



---
 rtl/spi_master_slave.sv | 215 +++++++++++++++++++++
 tb/tb_spi_master_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// spi_master_slave: 8-bit SPI master and slave joined by internal wires.
// One start request performs one full-duplex, MSB-first, mode-0 exchange
// that swaps the master and slave shift registers.
// Define SPI_ASSERT_EN to compile in the protocol checker (spi_master_slave_chk).

`ifdef SPI_ASSERT_EN
// Protocol checker for the parallel control port; silent on pass.
module spi_master_slave_chk (
  input logic mclk,
  input logic reset,
  input logic load_master,
  input logic load_slave,
  input logic read_master,
  input logic read_slave,
  input logic start,
  input logic busy
);
  a_load_read_master: assert property (@(posedge mclk) disable iff (!reset)
    load_master |-> !read_master)
    else $error("load_master asserted together with read_master");
  a_load_read_slave: assert property (@(posedge mclk) disable iff (!reset)
    load_slave |-> !read_slave)
    else $error("load_slave asserted together with read_slave");
  a_start_busy_load: assert property (@(posedge mclk) disable iff (!reset)
    !(start && busy && (load_master || load_slave)))
    else $error("start sampled while busy together with a load");
  a_ctrl_stable: assert property (@(posedge mclk) disable iff (!reset)
    busy |-> ($stable(load_master) && $stable(load_slave) &&
              $stable(read_master) && $stable(read_slave)))
    else $error("load/read changed while busy");
endmodule
`endif

module spi_master_slave #(
  parameter int CLK_DIV = 4
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       load_master,
  input  logic       load_slave,
  input  logic       read_master,
  input  logic       read_slave,
  input  logic       start,
  input  logic [7:0] data_in_master,
  input  logic [7:0] data_in_slave,
  output logic [7:0] data_out_master,
  output logic [7:0] data_out_slave,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic       miso,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_r;
  logic [7:0]    msr_r;
  logic [7:0]    ssr_r;
  logic [7:0]    dout_m_r;
  logic [7:0]    dout_s_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bitcnt_r;
  logic          mcap_r;
  logic          scap_r;
  logic          cs_r;
  logic          sclk_r;
  logic          busy_r;
  logic          done_r;

  logic          in_idle_s;
  logic          in_shift_s;
  logic          start_ok_s;
  logic          rise_s;
  logic          fall_s;
  logic          last_bit_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          mosi_s;
  logic          miso_s;

  // Link wires: slave only drives MISO while selected.
  assign mosi_s = msr_r[7];
  assign miso_s = cs_r ? 1'b0 : ssr_r[7];

  // Decode state and SCLK phase events from the registered counter.
  always_comb begin
    in_idle_s  = (state_r == ST_IDLE);
    in_shift_s = (state_r == ST_SHIFT);
    // A load in the same cycle takes priority over a start request.
    start_ok_s = in_idle_s && start && !load_master && !load_slave;
    rise_s     = in_shift_s && (cnt_r == CNT_HALF_M1);
    fall_s     = in_shift_s && (cnt_r == CNT_LAST);
    last_bit_s = fall_s && (bitcnt_r == 3'd7);
    if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Master FSM: IDLE -> SHIFT (8 bits) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  if (start_ok_s) state_r <= ST_SHIFT;
        ST_SHIFT: if (last_bit_s) state_r <= ST_DONE;
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Link timing: chip select, SCLK phase, bit counter and status flags.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      cs_r     <= 1'b1;
      sclk_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
      bitcnt_r <= 3'd0;
    end else if (start_ok_s) begin
      cs_r     <= 1'b0;
      sclk_r   <= 1'b0;
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
      bitcnt_r <= 3'd0;
    end else if (in_shift_s) begin
      cnt_r  <= cnt_nxt_s;
      // SCLK is high for the second half of each bit period.
      sclk_r <= (cnt_nxt_s >= CNT_HALF);
      if (fall_s) begin
        bitcnt_r <= bitcnt_r + 3'd1;
      end
      if (last_bit_s) begin
        cs_r   <= 1'b1;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      cs_r   <= 1'b1;
      sclk_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  // Datapath: parallel load/read in IDLE, sample on rise, shift on fall.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      msr_r    <= 8'h00;
      ssr_r    <= 8'h00;
      dout_m_r <= 8'h00;
      dout_s_r <= 8'h00;
      mcap_r   <= 1'b0;
      scap_r   <= 1'b0;
    end else if (in_idle_s) begin
      // Load beats read on the same side.
      if (load_master) begin
        msr_r <= data_in_master;
      end else if (read_master) begin
        dout_m_r <= msr_r;
      end
      if (load_slave) begin
        ssr_r <= data_in_slave;
      end else if (read_slave) begin
        dout_s_r <= ssr_r;
      end
    end else if (rise_s) begin
      mcap_r <= miso_s;
      scap_r <= mosi_s;
    end else if (fall_s) begin
      msr_r <= {msr_r[6:0], mcap_r};
      ssr_r <= {ssr_r[6:0], scap_r};
    end
  end

  assign data_out_master = dout_m_r;
  assign data_out_slave  = dout_s_r;
  assign sclk            = sclk_r;
  assign cs              = cs_r;
  assign mosi            = mosi_s;
  assign miso            = miso_s;
  assign busy            = busy_r;
  assign done            = done_r;

`ifdef SPI_ASSERT_EN
  spi_master_slave_chk u_chk (
    .mclk        (mclk),
    .reset       (reset),
    .load_master (load_master),
    .load_slave  (load_slave),
    .read_master (read_master),
    .read_slave  (read_slave),
    .start       (start),
    .busy        (busy_r)
  );
`else
  // Checker not compiled in this build; behaviour is identical.
`endif

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench for spi_master_slave: table of IDLE-port vectors plus
// hand-written swap, latency, ignored-control, back-to-back and reset sequences.
module tb_spi_master_slave;
  localparam int CLK_DIV = 4;
  localparam int XFER    = 8 * CLK_DIV;

  logic       mclk = 1'b0;
  logic       reset;
  logic       load_master, load_slave, read_master, read_slave, start;
  logic [7:0] data_in_master, data_in_slave;
  logic [7:0] data_out_master, data_out_slave;
  logic       sclk, cs, mosi, miso, busy, done;

  int checks = 0;
  int errors = 0;

  spi_master_slave #(.CLK_DIV(CLK_DIV)) dut (
    .mclk            (mclk),
    .reset           (reset),
    .load_master     (load_master),
    .load_slave      (load_slave),
    .read_master     (read_master),
    .read_slave      (read_slave),
    .start           (start),
    .data_in_master  (data_in_master),
    .data_in_slave   (data_in_slave),
    .data_out_master (data_out_master),
    .data_out_slave  (data_out_slave),
    .sclk            (sclk),
    .cs              (cs),
    .mosi            (mosi),
    .miso            (miso),
    .busy            (busy),
    .done            (done)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic       ld_m, ld_s, rd_m, rd_s, st;
    logic [7:0] din_m, din_s;
    logic [7:0] exp_m, exp_s;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic clear_inputs();
    load_master = 1'b0; load_slave = 1'b0;
    read_master = 1'b0; read_slave = 1'b0;
    start = 1'b0;
  endtask

  // Step until done is seen or a cycle budget expires; n = edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk1("done_seen", done, 1'b1);
  endtask

  task automatic load_both(input logic [7:0] m, input logic [7:0] s);
    load_master = 1'b1; load_slave = 1'b1;
    data_in_master = m; data_in_slave = s;
    step();
    clear_inputs();
  endtask

  task automatic read_both();
    read_master = 1'b1; read_slave = 1'b1;
    step();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises;
    int cs_high;
    logic prev_sclk;
    logic [7:0] mbits;

    //            ld_m  ld_s  rd_m  rd_s  st    din_m  din_s  exp_m  exp_s  busy
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 8'hA5, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 8'hA5, 8'h3C, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h3C, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 8'h5A, 8'h3C, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h11, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 8'h00, 8'h5A, 8'h11, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h77, 8'h11, 1'b0};

    clear_inputs();
    data_in_master = 8'h00; data_in_slave = 8'h00;
    reset = 1'b0;
    step();
    step();
    chk8("rst_dout_m", data_out_master, 8'h00);
    chk8("rst_dout_s", data_out_slave, 8'h00);
    chk1("rst_cs", cs, 1'b1);
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mosi", mosi, 1'b0);
    chk1("rst_miso", miso, 1'b0);
    reset = 1'b1;
    step();

    // IDLE port behaviour: loads, reads, load/read priority, start vs load.
    for (int i = 0; i < 11; i++) begin
      load_master = vecs[i].ld_m; load_slave = vecs[i].ld_s;
      read_master = vecs[i].rd_m; read_slave = vecs[i].rd_s;
      start = vecs[i].st;
      data_in_master = vecs[i].din_m; data_in_slave = vecs[i].din_s;
      step();
      clear_inputs();
      chk8($sformatf("vec%0d_dout_m", i), data_out_master, vecs[i].exp_m);
      chk8($sformatf("vec%0d_dout_s", i), data_out_slave, vecs[i].exp_s);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk1($sformatf("vec%0d_cs", i), cs, 1'b1);
    end

    // Swap and latency: A5 <-> 3C, count SCLK rises and collect MOSI bits.
    load_both(8'hA5, 8'h3C);
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("lat_cs_low", cs, 1'b0);
    chk1("lat_busy", busy, 1'b1);
    n = 0; rises = 0; cs_high = 0; mbits = 8'h00; prev_sclk = sclk;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        mbits = {mbits[6:0], mosi};
      end
      if (done !== 1'b1 && cs !== 1'b0) cs_high++;
      prev_sclk = sclk;
    end
    chki("lat_done_edges", n, XFER);
    chki("lat_cs_stays_low", cs_high, 0);
    chki("lat_sclk_rises", rises, 8);
    chk8("lat_mosi_bits", mbits, 8'hA5);
    chk1("lat_cs_at_done", cs, 1'b1);
    chk1("lat_busy_at_done", busy, 1'b0);
    step();
    chk1("lat_done_one_cycle", done, 1'b0);
    read_both();
    chk8("swap_dout_m", data_out_master, 8'h3C);
    chk8("swap_dout_s", data_out_slave, 8'hA5);

    // Ignored controls during SHIFT: load_master 0xFF and read_slave pulse.
    load_both(8'hC3, 8'h96);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    load_master = 1'b1; data_in_master = 8'hFF; read_slave = 1'b1;
    step();
    clear_inputs();
    chk1("ign_busy", busy, 1'b1);
    chk8("ign_dout_s_mid", data_out_slave, 8'hA5);
    wait_done(n);
    chk8("ign_dout_s_done", data_out_slave, 8'hA5);
    step();
    read_both();
    chk8("ign_dout_m", data_out_master, 8'h96);
    chk8("ign_dout_s", data_out_slave, 8'hC3);

    // Back-to-back: start held high, done-to-done period.
    start = 1'b1;
    wait_done(n);
    step();
    wait_done(n);
    chki("b2b_period", n + 1, XFER + 2);
    start = 1'b0;
    step();
    step();
    chk1("b2b_stops", busy, 1'b0);

    // Mid-transfer reset at bit 4.
    load_both(8'hA5, 8'h3C);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk1("mrst_in_shift", cs, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk1("mrst_cs", cs, 1'b1);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_sclk", sclk, 1'b0);
    chk1("mrst_mosi", mosi, 1'b0);
    chk1("mrst_miso", miso, 1'b0);
    read_both();
    chk8("mrst_dout_m", data_out_master, 8'h00);
    chk8("mrst_dout_s", data_out_slave, 8'h00);
    step();
    chk1("mrst_no_restart", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
